// File: rtl/tournament_chooser_update_if.sv
// tournament_chooser_update_if: lookup and resolve-event signals of the chooser table
interface tournament_chooser_update_if #(parameter int IDX_W = 6);
  logic             lookup_v;
  logic [IDX_W-1:0] lookup_idx;
  logic             choice_v;
  logic [1:0]       choice_prediction;
  logic             upd_v;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_global_pred;
  logic             upd_local_pred;
  logic             upd_taken;
  logic             upd_pending;
  logic             init_done;
  modport master (
    output lookup_v, lookup_idx, upd_v, upd_idx, upd_global_pred, upd_local_pred, upd_taken,
    input  choice_v, choice_prediction, upd_ready, upd_pending, init_done
  );
  modport slave (
    input  lookup_v, lookup_idx, upd_v, upd_idx, upd_global_pred, upd_local_pred, upd_taken,
    output choice_v, choice_prediction, upd_ready, upd_pending, init_done
  );
endinterface

// File: rtl/tournament_chooser_update.sv
// tournament_chooser_update: chooser counter table with registered lookups and FIFO-buffered training
module tournament_chooser_update #(
  parameter int         IDX_W      = 6,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_VAL   = 2'b01
) (
  input logic clk,
  input logic reset,
  tournament_chooser_update_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic {INIT, RUN} state_t;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic [PW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             choice_v_q, choice_v_d;
  logic [1:0]       choice_pred_q, choice_pred_d;
  logic [1:0]       tbl [2**IDX_W];
  logic [IDX_W-1:0] fifo_idx [FIFO_DEPTH];
  logic             fifo_up [FIFO_DEPTH];
  logic             fifo_dn [FIFO_DEPTH];
  logic             run, empty, full, enq, deq, up, dn, tbl_we;
  logic [PW-1:0]    head;
  logic [IDX_W-1:0] hidx, tbl_wa;
  logic [1:0]       cnt, new_cnt, tbl_wd;
  // next-state, FIFO control and the single table write port (init sweep or drain RMW)
  always_comb begin
    run           = state_q == RUN;
    empty         = wr_ptr_q == rd_ptr_q;
    full          = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    enq           = run && bus.upd_v && !full;
    deq           = run && !empty && !bus.lookup_v;
    up            = (bus.upd_global_pred == bus.upd_taken) && (bus.upd_local_pred != bus.upd_taken);
    dn            = (bus.upd_global_pred != bus.upd_taken) && (bus.upd_local_pred == bus.upd_taken);
    head          = rd_ptr_q[PW-1:0];
    hidx          = fifo_idx[head];
    cnt           = tbl[hidx];
    new_cnt       = fifo_up[head] ? ((cnt == 2'b11) ? cnt : cnt + 2'd1) :
                    fifo_dn[head] ? ((cnt == 2'b00) ? cnt : cnt - 2'd1) : cnt;
    tbl_we        = !run || (deq && (fifo_up[head] || fifo_dn[head]));
    tbl_wa        = run ? hidx : init_ptr_q;
    tbl_wd        = run ? new_cnt : INIT_VAL;
    state_d       = (!run && &init_ptr_q) ? RUN : state_q;
    init_ptr_d    = run ? init_ptr_q : init_ptr_q + 1'b1;
    wr_ptr_d      = wr_ptr_q + (PW+1)'(enq);
    rd_ptr_d      = rd_ptr_q + (PW+1)'(deq);
    choice_v_d    = run && bus.lookup_v;
    choice_pred_d = choice_v_d ? tbl[bus.lookup_idx] : choice_pred_q;
  end
  // control state, FIFO pointers and registered lookup result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= INIT;
      init_ptr_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      choice_v_q    <= 1'b0;
      choice_pred_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      init_ptr_q    <= init_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      choice_v_q    <= choice_v_d;
      choice_pred_q <= choice_pred_d;
    end
  end
  // storage arrays; contents are rebuilt by the init sweep so they need no reset
  always_ff @(posedge clk) begin
    if (tbl_we) tbl[tbl_wa] <= tbl_wd;
    if (enq) begin
      fifo_idx[wr_ptr_q[PW-1:0]] <= bus.upd_idx;
      fifo_up[wr_ptr_q[PW-1:0]]  <= up;
      fifo_dn[wr_ptr_q[PW-1:0]]  <= dn;
    end
  end
  assign bus.choice_v          = choice_v_q;
  assign bus.choice_prediction = choice_pred_q;
  assign bus.upd_ready         = run && !full;
  assign bus.upd_pending       = !empty;
  assign bus.init_done         = run;
endmodule

// File: tb/tb_tournament_chooser_update.sv
// tb_tournament_chooser_update: directed checks of init, lookup, training, FIFO backpressure and reset
module tb_tournament_chooser_update;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int passed = 0;
  tournament_chooser_update_if #(.IDX_W(6)) bus ();
  tournament_chooser_update #(.IDX_W(6), .FIFO_DEPTH(4), .INIT_VAL(2'b01)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic lookup(input logic [5:0] idx, input logic [1:0] exp, input string tag);
    bus.lookup_v = 1'b1;
    bus.lookup_idx = idx;
    tick();
    bus.lookup_v = 1'b0;
    chk({tag, "_v"}, bus.choice_v, 1);
    chk(tag, bus.choice_prediction, exp);
  endtask
  task automatic send(input logic [5:0] idx, input logic g, input logic l, input logic t);
    bus.upd_v = 1'b1;
    bus.upd_idx = idx;
    bus.upd_global_pred = g;
    bus.upd_local_pred = l;
    bus.upd_taken = t;
    chk("send_ready", bus.upd_ready, 1);
    tick();
    bus.upd_v = 1'b0;
    tick();
  endtask
  task automatic wait_init(input string tag);
    int n = 0;
    while (!bus.init_done && n < 200) begin
      tick();
      n++;
    end
    chk(tag, bus.init_done, 1);
  endtask
  initial begin
    int acc;
    logic bad;
    bus.lookup_v = 0; bus.lookup_idx = 0; bus.upd_v = 0; bus.upd_idx = 0;
    bus.upd_global_pred = 0; bus.upd_local_pred = 0; bus.upd_taken = 0;
    tick(); tick();
    chk("rst_choice_v", bus.choice_v, 0);
    chk("rst_pred", bus.choice_prediction, 0);
    chk("rst_ready", bus.upd_ready, 0);
    chk("rst_pending", bus.upd_pending, 0);
    chk("rst_init_done", bus.init_done, 0);
    reset = 1'b0;
    bus.lookup_v = 1'b1; bus.lookup_idx = 5; bus.upd_v = 1'b1; bus.upd_idx = 5;
    bus.upd_global_pred = 0; bus.upd_local_pred = 1; bus.upd_taken = 1;
    bad = 1'b0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (bus.init_done || bus.upd_ready || bus.choice_v || bus.upd_pending) bad = 1'b1;
    end
    chk("init_quiet_63", bad, 0);
    bus.lookup_v = 1'b0; bus.upd_v = 1'b0;
    tick();
    chk("init_done_64", bus.init_done, 1);
    chk("run_ready", bus.upd_ready, 1);
    chk("run_pending", bus.upd_pending, 0);
    lookup(5, 2'b01, "init_idx5");
    tick();
    chk("choice_v_drop", bus.choice_v, 0);
    chk("pred_hold", bus.choice_prediction, 2'b01);
    send(5, 1, 0, 1); lookup(5, 2'b10, "inc1");
    send(5, 1, 0, 1); lookup(5, 2'b11, "inc2");
    send(5, 1, 0, 1); lookup(5, 2'b11, "inc_sat");
    send(9, 0, 1, 1); lookup(9, 2'b00, "dec1");
    send(9, 0, 1, 1); lookup(9, 2'b00, "dec_sat");
    send(9, 1, 1, 1); lookup(9, 2'b00, "both_right");
    send(9, 0, 0, 1); lookup(9, 2'b00, "both_wrong");
    bus.lookup_v = 1'b1; bus.lookup_idx = 0;
    bus.upd_idx = 7; bus.upd_global_pred = 1; bus.upd_local_pred = 0; bus.upd_taken = 1;
    bus.upd_v = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      acc += int'(bus.upd_ready);
      tick();
    end
    bus.upd_v = 1'b0;
    chk("full_accepted", acc, 4);
    chk("full_ready", bus.upd_ready, 0);
    chk("full_pending", bus.upd_pending, 1);
    bus.lookup_v = 1'b0;
    tick(); tick(); tick();
    chk("drain3_pending", bus.upd_pending, 1);
    tick();
    chk("drain4_pending", bus.upd_pending, 0);
    chk("drain4_ready", bus.upd_ready, 1);
    lookup(7, 2'b11, "idx7_after4");
    bus.upd_v = 1'b1; bus.upd_idx = 3; bus.upd_global_pred = 1; bus.upd_local_pred = 0; bus.upd_taken = 1;
    tick(); tick();
    bus.upd_v = 1'b0;
    tick(); tick();
    chk("b2b_pending", bus.upd_pending, 0);
    lookup(3, 2'b11, "b2b_idx3");
    bus.lookup_v = 1'b1; bus.lookup_idx = 5;
    bus.upd_v = 1'b1; bus.upd_idx = 5; bus.upd_global_pred = 0; bus.upd_local_pred = 1; bus.upd_taken = 1;
    tick(); tick(); tick();
    bus.upd_v = 1'b0;
    chk("pre_rst_pending", bus.upd_pending, 1);
    chk("pre_rst_pred", bus.choice_prediction, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("async_choice_v", bus.choice_v, 0);
    chk("async_pred", bus.choice_prediction, 0);
    chk("async_pending", bus.upd_pending, 0);
    chk("async_ready", bus.upd_ready, 0);
    chk("async_init_done", bus.init_done, 0);
    bus.lookup_v = 1'b0;
    tick();
    reset = 1'b0;
    wait_init("reinit_done");
    chk("reinit_pending", bus.upd_pending, 0);
    lookup(5, 2'b01, "reinit_idx5");
    lookup(7, 2'b01, "reinit_idx7");
    tick(); tick(); tick();
    lookup(5, 2'b01, "reinit_idx5_later");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
